// File: rtl/payload_engine_pkg.sv
// payload_engine_pkg: shared state encoding and defaults for the payload engine sequencer
package payload_engine_pkg;
  localparam int PE_DRAIN_CYCLES = 2;
  localparam int PE_LEN_W = 16;
  typedef enum logic [2:0] {IDLE, STREAM, DRAIN, CAPTURE, REPORT} pe_state_t;
endpackage

// File: rtl/payload_result_reg.sv
// payload_result_reg: per-packet result capture register with valid/ready handshake
module payload_result_reg #(
  parameter int NUM_ENGINES = 64,
  parameter int LEN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cap,
  input  logic [NUM_ENGINES-1:0] eng_match,
  input  logic [LEN_W-1:0]       len,
  input  logic                   res_ready,
  output logic                   res_valid,
  output logic [NUM_ENGINES-1:0] res_match,
  output logic                   res_any,
  output logic [LEN_W-1:0]       res_len
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_match <= '0;
      res_any <= 1'b0;
      res_len <= '0;
    end else if (cap) begin
      res_valid <= 1'b1;
      res_match <= eng_match;
      res_any <= |eng_match;
      res_len <= len;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/payload_engine_ctrl.sv
// payload_engine_ctrl: streams packet bytes into the engine bank, drains it and reports matches
module payload_engine_ctrl
  import payload_engine_pkg::*;
#(
  parameter int NUM_ENGINES = 64,
  parameter int DRAIN_CYCLES = PE_DRAIN_CYCLES,
  parameter int LEN_W = PE_LEN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic                   eng_sod,
  output logic                   eng_en,
  output logic [7:0]             eng_char,
  output logic                   eng_char_vld,
  input  logic [NUM_ENGINES-1:0] eng_match,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [NUM_ENGINES-1:0] res_match,
  output logic                   res_any,
  output logic [LEN_W-1:0]       res_len
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  pe_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [LEN_W-1:0] len;
  logic acc, cnt_zero;
  assign s_ready = state == STREAM;
  assign acc = s_valid & s_ready;
  assign cnt_zero = cnt == '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = s_valid ? STREAM : IDLE;
      STREAM:  state_n = (acc && s_last) ? DRAIN : STREAM;
      DRAIN:   state_n = cnt_zero ? CAPTURE : DRAIN;
      CAPTURE: state_n = REPORT;
      REPORT:  state_n = res_ready ? IDLE : REPORT;
      default: state_n = IDLE;
    endcase
  end
  // drain counter reloads outside DRAIN; the zero-count DRAIN cycle issues no step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      len <= '0;
      eng_sod <= 1'b1;
      eng_en <= 1'b0;
      eng_char <= '0;
      eng_char_vld <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state != DRAIN) ? CW'(DRAIN_CYCLES) : cnt_zero ? cnt : cnt - CW'(1);
      len <= (state == REPORT && res_ready) ? '0 : (acc && !(&len)) ? len + LEN_W'(1) : len;
      eng_sod <= state_n == IDLE || state_n == REPORT;
      eng_en <= acc || (state == DRAIN && !cnt_zero);
      eng_char_vld <= acc;
      if (acc) eng_char <= s_data;
    end
  end
  payload_result_reg #(.NUM_ENGINES(NUM_ENGINES), .LEN_W(LEN_W)) u_res (
    .clk(clk),
    .rst_n(rst_n),
    .cap(state == CAPTURE),
    .eng_match(eng_match),
    .len(len),
    .res_ready(res_ready),
    .res_valid(res_valid),
    .res_match(res_match),
    .res_any(res_any),
    .res_len(res_len)
  );
endmodule

// File: tb/tb_payload_engine_ctrl.sv
// tb_payload_engine_ctrl: timeline model of the sequencer plus directed packet scenarios
module tb_payload_engine_ctrl;
  localparam int D = 2;
  logic clk = 0, rst_n = 0;
  logic [7:0] s_data = 0;
  logic s_valid = 0, s_last = 0, res_ready = 1;
  logic [63:0] eng_match;
  logic s_ready, eng_sod, eng_en, eng_char_vld, res_valid, res_any;
  logic [7:0] eng_char;
  logic [63:0] res_match;
  logic [15:0] res_len;
  logic t_s_ready, t_eng_sod, t_eng_en, t_eng_char_vld, t_res_valid, t_res_any;
  logic [7:0] t_eng_char;
  logic [63:0] t_res_match;
  logic [3:0] t_res_len;
  int n_err = 0, n_chk = 0;
  int cyc = 0;
  logic [63:0] pkt_pat = 0;
  int dc;
  logic [7:0] pb [32];

  payload_engine_ctrl dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .eng_sod(eng_sod), .eng_en(eng_en), .eng_char(eng_char),
    .eng_char_vld(eng_char_vld), .eng_match(eng_match), .res_valid(res_valid),
    .res_ready(res_ready), .res_match(res_match), .res_any(res_any), .res_len(res_len)
  );
  payload_engine_ctrl #(.LEN_W(4)) sat (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(t_s_ready), .eng_sod(t_eng_sod), .eng_en(t_eng_en), .eng_char(t_eng_char),
    .eng_char_vld(t_eng_char_vld), .eng_match(eng_match), .res_valid(t_res_valid),
    .res_ready(res_ready), .res_match(t_res_match), .res_any(t_res_any), .res_len(t_res_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // engine bank stand-in: sticky match appears once the final drain step lands
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_match <= '0;
      dc <= 0;
    end else if (eng_sod) begin
      eng_match <= '0;
      dc <= 0;
    end else if (eng_en && !eng_char_vld) begin
      dc <= dc + 1;
      if (dc == D - 1) eng_match <= pkt_pat;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {int c; bit vld; logic [7:0] ch;} pulse_t;
  typedef struct {logic [63:0] m; int len;} rec_t;
  pulse_t pq[$];
  rec_t rq[$];
  bit m_idle = 1, m_ready = 0, m_sodlow = 0;
  int res_due = -1, pkt_n = 0;

  always @(negedge clk) begin
    bit rv_exp, en_exp, nxt_ready, nxt_idle;
    if (!rst_n) begin
      pq.delete();
      rq.delete();
      m_idle = 1;
      m_ready = 0;
      m_sodlow = 0;
      res_due = -1;
      pkt_n = 0;
    end else begin
      while (pq.size() > 0 && pq[0].c < cyc) void'(pq.pop_front());
      rv_exp = rq.size() > 0 && cyc >= res_due;
      en_exp = pq.size() > 0 && pq[0].c == cyc;
      chk("s_ready", s_ready, m_ready);
      chk("sat_s_ready", t_s_ready, m_ready);
      chk("eng_sod", eng_sod, !m_sodlow);
      chk("sat_eng_sod", t_eng_sod, !m_sodlow);
      chk("eng_en", eng_en, en_exp);
      chk("sat_eng_en", t_eng_en, en_exp);
      if (en_exp) begin
        chk("eng_char_vld", eng_char_vld, pq[0].vld);
        chk("sat_eng_char_vld", t_eng_char_vld, pq[0].vld);
        if (pq[0].vld) begin
          chk("eng_char", eng_char, pq[0].ch);
          chk("sat_eng_char", t_eng_char, pq[0].ch);
        end
        void'(pq.pop_front());
      end
      chk("res_valid", res_valid, rv_exp);
      chk("sat_res_valid", t_res_valid, rv_exp);
      if (rv_exp) begin
        chk("res_match", res_match, rq[0].m);
        chk("res_any", res_any, |rq[0].m);
        chk("res_len", res_len, 64'(rq[0].len > 65535 ? 65535 : rq[0].len));
        chk("sat_res_match", t_res_match, rq[0].m);
        chk("sat_res_any", t_res_any, |rq[0].m);
        chk("sat_res_len", t_res_len, 64'(rq[0].len > 15 ? 15 : rq[0].len));
      end
      nxt_ready = m_ready;
      nxt_idle = m_idle;
      if (m_idle && s_valid) begin
        nxt_ready = 1;
        nxt_idle = 0;
        m_sodlow = 1;
      end
      if (m_ready && s_valid) begin
        pq.push_back('{cyc + 1, 1'b1, s_data});
        pkt_n++;
        if (s_last) begin
          for (int d = 1; d <= D; d++) pq.push_back('{cyc + 1 + d, 1'b0, 8'h00});
          nxt_ready = 0;
          res_due = cyc + 3 + D;
          rq.push_back('{pkt_pat, pkt_n});
          pkt_n = 0;
        end
      end
      if (m_sodlow && rq.size() > 0 && cyc + 1 == res_due) m_sodlow = 0;
      if (rv_exp && res_ready) begin
        void'(rq.pop_front());
        nxt_idle = 1;
      end
      m_ready = nxt_ready;
      m_idle = nxt_idle;
    end
  end

  int nv = 0, nd = 0, rise_cyc = 0, hs_cyc = 0, first_acc = 0, last_acc = 0;
  int obs_len = 0, obs_sat_len = 0;
  logic [63:0] obs_match = 0;
  logic obs_any = 0, rv_q = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (eng_en) begin
        if (eng_char_vld) nv++;
        else nd++;
      end
      if (res_valid && !rv_q) begin
        rise_cyc = cyc;
        obs_len = int'(res_len);
        obs_sat_len = int'(t_res_len);
        obs_match = res_match;
        obs_any = res_any;
      end
      if (res_valid && res_ready) hs_cyc = cyc;
      rv_q = res_valid;
    end else rv_q = 0;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, output int acc_c);
    int t = 0;
    s_valid = 1;
    s_data = b;
    s_last = last;
    do begin
      @(negedge clk);
      t++;
    end while (!s_ready && t < 200);
    if (!s_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_timeout: s_ready stayed 0, required 1 within 200 cycles");
    end
    acc_c = cyc;
    step(1);
    s_valid = 0;
    s_last = 0;
  endtask

  task automatic send_pkt(input int n, input bit gaps);
    int c;
    for (int i = 0; i < n; i++) begin
      send_byte(pb[i], i == n - 1, c);
      if (i == 0) first_acc = c;
      last_acc = c;
      if (gaps && i < n - 1) step($urandom_range(0, 2));
    end
  endtask

  task automatic wait_sig(input string nm, input bit hs);
    int t = 0;
    bit done = 0;
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
      done = hs ? (res_valid && res_ready) : res_valid;
    end
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_timeout: got no event, required one within 200 cycles", nm);
    end
    step(1);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_s_ready"}, s_ready, 0);
    chk({nm, "_eng_sod"}, eng_sod, 1);
    chk({nm, "_eng_en"}, eng_en, 0);
    chk({nm, "_eng_char"}, eng_char, 0);
    chk({nm, "_eng_char_vld"}, eng_char_vld, 0);
    chk({nm, "_res_valid"}, res_valid, 0);
    chk({nm, "_res_match"}, res_match, 0);
    chk({nm, "_res_any"}, res_any, 0);
    chk({nm, "_res_len"}, res_len, 0);
  endtask

  initial begin
    string s = "jaiku.com";
    int c;
    step(3);
    check_reset("init");
    rst_n = 1;
    step(2);
    // 9-byte packet, single engine fires after the last byte
    for (int i = 0; i < 9; i++) pb[i] = s[i];
    nv = 0; nd = 0;
    pkt_pat = 64'h0000_0020_0000_0000;
    send_pkt(9, 0);
    wait_sig("t1", 1);
    chk("t1_en_vld_pulses", nv, 9);
    chk("t1_en_drain_pulses", nd, 2);
    chk("t1_res_latency", rise_cyc - last_acc, 5);
    chk("t1_res_len", obs_len, 9);
    chk("t1_res_any", obs_any, 1);
    chk("t1_res_match", obs_match, 64'h0000_0020_0000_0000);
    // 1-byte packet, no match
    nv = 0; nd = 0;
    pkt_pat = 0;
    pb[0] = 8'h5a;
    send_pkt(1, 0);
    wait_sig("t2", 1);
    chk("t2_en_pulses", nv + nd, 3);
    chk("t2_res_len", obs_len, 1);
    chk("t2_res_any", obs_any, 0);
    chk("t2_res_match", obs_match, 0);
    // 20 bytes with gaps; 4-bit length copy saturates
    nv = 0;
    pkt_pat = 64'h8000_0000_0000_0101;
    for (int i = 0; i < 20; i++) pb[i] = 8'($urandom);
    send_pkt(20, 1);
    wait_sig("t3", 1);
    chk("t3_en_vld_pulses", nv, 20);
    chk("t3_res_len", obs_len, 20);
    chk("t3_sat_res_len", obs_sat_len, 15);
    // downstream back-pressure with the next packet already waiting
    res_ready = 0;
    pkt_pat = 64'h3;
    for (int i = 0; i < 4; i++) pb[i] = 8'h41 + 8'(i);
    send_pkt(4, 0);
    wait_sig("t4_rv", 0);
    pkt_pat = 64'h10;
    pb[0] = 8'h61;
    pb[1] = 8'h62;
    s_valid = 1;
    s_data = pb[0];
    step(10);
    chk("t4_hold_valid", res_valid, 1);
    chk("t4_hold_len", res_len, 4);
    chk("t4_hold_match", res_match, 64'h3);
    chk("t4_hold_s_ready", s_ready, 0);
    chk("t4_hold_sod", eng_sod, 1);
    res_ready = 1;
    send_pkt(2, 0);
    chk("t4_next_accept_gap", first_acc - hs_cyc, 2);
    wait_sig("t4b", 1);
    chk("t4b_res_len", obs_len, 2);
    // asynchronous reset in the middle of a packet
    pkt_pat = 64'hff;
    for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i), 0, c);
    chk("t5_pre_reset_en", eng_en, 1);
    #1;
    rst_n = 0;
    #1;
    check_reset("t5_async");
    step(2);
    rst_n = 1;
    step(1);
    pkt_pat = 64'h8000_0000_0000_0000;
    for (int i = 0; i < 3; i++) pb[i] = 8'h70 + 8'(i);
    send_pkt(3, 0);
    wait_sig("t5", 1);
    chk("t5_res_len", obs_len, 3);
    chk("t5_res_match", obs_match, 64'h8000_0000_0000_0000);
    step(3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end
endmodule

// File: doc/payload_engine_ctrl.md
# payload_engine_ctrl

Sequencer for one bank of `engine_*` payload matchers. It accepts a packet payload as a byte stream and drives the shared engine controls:
- `eng_sod`: clears every engine state flop.
- `eng_en`: clock enable for one character step.
- `eng_char` / `eng_char_vld`: feeds the character-class decoder.

After the last byte it drains the engines' pipeline, captures the sticky match outputs, and presents one result record per packet to the downstream alert logic.

## Interface
- `NUM_ENGINES`, 64: number of engine `out` bits collected.
- `DRAIN_CYCLES`, 2: `eng_en` pulses issued after the last byte with `eng_char_vld=0`. Covers the last state flop plus the End-state flop.
- `LEN_W`, 16: payload length counter width.

- `clk`  in  1  clock, single domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_data`  in  8  payload byte.
- `s_valid`  in  1  byte valid.
- `s_last`  in  1  final byte of packet, qualified by `s_valid`.
- `s_ready`  out  1  byte accepted when `s_valid & s_ready`.
- `eng_sod`  out  1  engine clear, active high; drives every engine `sod`.
- `eng_en`  out  1  engine step enable.
- `eng_char`  out  8  registered byte to the class decoder.
- `eng_char_vld`  out  1  0 forces every decoder class line low.
- `eng_match`  in  NUM_ENGINES  engine `out` bits, sticky.
- `res_valid`  out  1  result record valid.
- `res_ready`  in  1  downstream accepts record.
- `res_match`  out  NUM_ENGINES  captured match vector.
- `res_any`  out  1  OR of `res_match`.
- `res_len`  out  LEN_W  payload bytes, saturating at all-ones.

## Operation
The FSM has five states.

- **IDLE**
  - `eng_sod=1`, `s_ready=0`, `eng_en=0`.
  - On `s_valid` go to STREAM. The byte is not consumed here.
- **STREAM**
  - `eng_sod=0`, `s_ready=1`.
  - Each accepted byte registers `eng_char<=s_data`, `eng_char_vld<=1`, `eng_en<=1` for exactly one cycle, and increments the length counter (saturating).
  - No accept means `eng_en<=0` and engine state holds.
  - Accepted byte with `s_last`: go to DRAIN with drain counter = `DRAIN_CYCLES`.
- **DRAIN**
  - `s_ready=0`.
  - Each cycle: `eng_en<=1`, `eng_char_vld<=0`, decrement the counter.
  - At 0 go to CAPTURE.
- **CAPTURE**
  - `eng_en=0`.
  - `res_match<=eng_match`, `res_any<=|eng_match`, `res_len<=` counter.
  - Next state REPORT.
- **REPORT**
  - `res_valid=1`, `eng_sod=1`; engines clear while the record is pending.
  - `res_match`, `res_len` and `res_any` are stable until the handshake.
  - On `res_ready` go to IDLE and clear the length counter.

Boundary conditions:
- A 1-byte packet (`s_last` on the first beat) is legal and follows the full sequence.
- `s_valid` during DRAIN, CAPTURE or REPORT stalls, because `s_ready=0`.
- `res_ready` held high permanently is legal. REPORT lasts exactly 1 cycle.
- Length saturates: a packet longer than 2^LEN_W-1 bytes reports all-ones and matching continues unaffected.
- Reset mid-packet: all outputs go to reset values immediately, state goes to IDLE, and engines are cleared. Upstream must resynchronise to a packet boundary.

Reset values: state IDLE, `eng_sod=1`, `eng_en=0`, `eng_char=0`, `eng_char_vld=0`, `s_ready=0`, `res_valid=0`, `res_match=0`, `res_any=0`, `res_len=0`.

## Timing
- All outputs are registered except `s_ready`, which is decoded from the state.
- Byte accepted at edge N: `eng_en`/`eng_char` are high during cycle N+1 and the engine flops update at edge N+2.
- Last byte accepted at edge N:
  - DRAIN pulses in cycles N+2 .. N+1+DRAIN_CYCLES.
  - CAPTURE follows.
  - `res_valid` rises at edge N+3+DRAIN_CYCLES. With defaults that is 5 cycles after the last accept.
- Per-packet overhead: 1 IDLE cycle, then DRAIN_CYCLES, then CAPTURE, then REPORT (at least 1 cycle).
- Maximum throughput is 1 byte/cycle inside STREAM.

## Structure
- Shared package `payload_engine_pkg`:
  - FSM state enum: IDLE, STREAM, DRAIN, CAPTURE, REPORT.
  - Default `DRAIN_CYCLES`.
  - `LEN_W`.
- One natural sub-module: `payload_result_reg`. It holds the capture/hold register for match, any and len plus the `res_valid`/`res_ready` handshake.
- The character-class decoder stays outside this block.

## Test plan
- **"jaiku.com"-style 9-byte packet, one engine asserting `out` after the last byte, `res_ready=1`:**
  - Exactly 9 `eng_en` pulses with `eng_char_vld=1`, then 2 with `eng_char_vld=0`.
  - `res_valid` 5 cycles after the last accept.
  - `res_len=9`, `res_any=1`, the correct single bit set.
- **1-byte packet, no match:**
  - `res_len=1`, `res_match=0`, `res_any=0`.
  - `eng_sod` low only from STREAM entry to REPORT entry.
- **Random `s_valid` gaps within a 20-byte packet:**
  - `eng_en` pulses count equals accepted bytes.
  - `eng_char` sequence equals the input sequence.
  - `res_len=20`.
- **`res_ready` held low for 10 cycles:**
  - `res_*` stable.
  - `s_ready=0`.
  - `eng_sod=1` throughout.
  - Next packet accepted only after the handshake plus the IDLE cycle.
- **`rst_n` pulsed low mid-packet at byte 5:**
  - All outputs take reset values asynchronously.
  - A following clean 3-byte packet reports `res_len=3`.
- **Length saturation with `LEN_W=4`, 20-byte packet:** `res_len=15`.
